// File: rtl/cpu_defs.sv
// Shared definitions for the multiply/divide unit: op bit positions,
// controller state encoding and divider iteration count.
package cpu_defs;

  // Bit positions inside the one-hot hi_lo_op group
  localparam int HLOP_DIV   = 0;
  localparam int HLOP_DIVU  = 1;
  localparam int HLOP_MULT  = 2;
  localparam int HLOP_MULTU = 3;
  localparam int HLOP_MTHI  = 4;
  localparam int HLOP_MTLO  = 5;
  localparam int HLOP_MFHI  = 6;
  localparam int HLOP_MFLO  = 7;

  // Radix-2 divider produces one quotient bit per step
  localparam int DIV_ITERS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } mdu_state_t;

endpackage

// File: rtl/mdu_div_radix2.sv
// Iterative radix-2 restoring divider datapath on unsigned magnitudes.
// load captures the operands; each step retires one quotient bit.
// A zero divisor naturally yields quot=all ones and rem=dividend.
module mdu_div_radix2 (
  input  logic        clk,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  logic [31:0] quot_q, quot_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dsr_q, dsr_d;
  logic [32:0] rem_sh;
  logic [32:0] trial;

  // Shift partial remainder, trial-subtract divisor, keep or restore
  always_comb begin
    rem_sh = {rem_q, quot_q[31]};
    trial  = rem_sh - {1'b0, dsr_q};
    quot_d = quot_q;
    rem_d  = rem_q;
    dsr_d  = dsr_q;
    if (load) begin
      quot_d = dividend;
      rem_d  = '0;
      dsr_d  = divisor;
    end else if (step) begin
      if (!trial[32]) begin
        rem_d  = trial[31:0];
        quot_d = {quot_q[30:0], 1'b1};
      end else begin
        rem_d  = rem_sh[31:0];
        quot_d = {quot_q[30:0], 1'b0};
      end
    end
  end

  // Datapath registers; contents are don't-care until a load
  always_ff @(posedge clk) begin
    quot_q <= quot_d;
    rem_q  <= rem_d;
    dsr_q  <= dsr_d;
  end

  assign quot = quot_q;
  assign rem  = rem_q;

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller for the EX stage. Owns HI/LO, sequences a
// pipelined multiplier and the radix-2 divider, and applies the sign fix.
module mdu_ctrl
  import cpu_defs::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [7:0]  hi_lo_op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        flush,
  output logic        op_done,
  output logic [31:0] res,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_t         state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic signed [32:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic               neg_quot_q, neg_quot_d, neg_rem_q, neg_rem_d;
  logic               legal_op, go, is_mul, is_div, div_signed;
  logic               div_load, div_step;
  logic [31:0]        dividend_mag, divisor_mag, div_quot, div_rem;
  logic signed [63:0] prod_p0, prod_out;

  assign legal_op     = $onehot(hi_lo_op);
  assign go           = op_valid & ~flush & legal_op;
  assign is_mul       = hi_lo_op[HLOP_MULT] | hi_lo_op[HLOP_MULTU];
  assign is_div       = hi_lo_op[HLOP_DIV] | hi_lo_op[HLOP_DIVU];
  assign div_signed   = hi_lo_op[HLOP_DIV];
  assign dividend_mag = (div_signed && src1[31]) ? -src1 : src1;
  assign divisor_mag  = (div_signed && src2[31]) ? -src2 : src2;

  // 33x33 signed product of the latched operands; low 64 bits are the result
  assign prod_p0 = 64'(mul_a_q) * 64'(mul_b_q);

  if (MUL_LAT == 1) begin : g_mul_comb
    assign prod_out = prod_p0;
  end else begin : g_mul_pipe
    logic signed [63:0] pipe_q [MUL_LAT-1];
    // Product pipeline so the result lands exactly MUL_LAT cycles after accept
    always_ff @(posedge clk) begin
      pipe_q[0] <= prod_p0;
      for (int i = 1; i < MUL_LAT - 1; i++) pipe_q[i] <= pipe_q[i-1];
    end
    assign prod_out = pipe_q[MUL_LAT-2];
  end

  mdu_div_radix2 u_div (
    .clk      (clk),
    .load     (div_load),
    .step     (div_step),
    .dividend (dividend_mag),
    .divisor  (divisor_mag),
    .quot     (div_quot),
    .rem      (div_rem)
  );

  // State, counter and architectural HI/LO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Operand and sign capture at accept; no reset needed
  always_ff @(posedge clk) begin
    mul_a_q    <= mul_a_d;
    mul_b_q    <= mul_b_d;
    neg_quot_q <= neg_quot_d;
    neg_rem_q  <= neg_rem_d;
  end

  // Next state and counter; flush always returns to IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (go && is_mul) begin
          state_d = MUL;
          cnt_d   = 5'(MUL_LAT - 1);
        end else if (go && is_div) begin
          state_d = DIV;
          cnt_d   = '0;
        end
        MUL:  if (cnt_q == '0) state_d = IDLE;
              else cnt_d = cnt_q - 5'd1;
        DIV: begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(DIV_ITERS - 1)) state_d = FIX;
        end
        FIX:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs, HI/LO writes and divider control
  always_comb begin
    op_done  = 1'b0;
    res      = '0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    div_load = 1'b0;
    div_step = 1'b0;
    case (state_q)
      IDLE: if (go) begin
        if (hi_lo_op[HLOP_MTHI]) begin op_done = 1'b1; hi_d = src1; end
        if (hi_lo_op[HLOP_MTLO]) begin op_done = 1'b1; lo_d = src1; end
        if (hi_lo_op[HLOP_MFHI]) begin op_done = 1'b1; res = hi_q; end
        if (hi_lo_op[HLOP_MFLO]) begin op_done = 1'b1; res = lo_q; end
        div_load = is_div;
      end
      MUL: if (!flush && cnt_q == '0) begin
        op_done = 1'b1;
        hi_d    = prod_out[63:32];
        lo_d    = prod_out[31:0];
      end
      DIV: div_step = ~flush;
      FIX: if (!flush) begin
        op_done = 1'b1;
        lo_d    = neg_quot_q ? -div_quot : div_quot;
        hi_d    = neg_rem_q ? -div_rem : div_rem;
      end
      default: ;
    endcase
  end

  // Operand latch: sign/zero-extend multiplicands, record divide sign fix
  always_comb begin
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    if (state_q == IDLE && go && is_mul) begin
      mul_a_d = hi_lo_op[HLOP_MULT] ? {src1[31], src1} : {1'b0, src1};
      mul_b_d = hi_lo_op[HLOP_MULT] ? {src2[31], src2} : {1'b0, src2};
    end
    if (state_q == IDLE && go && is_div) begin
      neg_quot_d = div_signed & (src1[31] ^ src2[31]);
      neg_rem_d  = div_signed & src1[31];
    end
  end

  assign busy = (state_q != IDLE);
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Protocol checks: op held until completion, never more than one op bit
  a_hold_valid: assert property (@(posedge clk) disable iff (reset)
    (state_q != IDLE && !flush) |-> op_valid);
  a_onehot_op: assert property (@(posedge clk) disable iff (reset)
    op_valid |-> $onehot0(hi_lo_op));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed corner cases plus random ops
// checked against an arithmetic model of HI/LO.
module tb_mdu_ctrl;

  localparam int MUL_LAT = 2;

  logic        clk, reset, op_valid, flush;
  logic [7:0]  hi_lo_op;
  logic [31:0] src1, src2;
  logic        op_done, busy;
  logic [31:0] res, hi, lo;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mdu_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .hi_lo_op (hi_lo_op),
    .src1     (src1),
    .src2     (src2),
    .flush    (flush),
    .op_done  (op_done),
    .res      (res),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, wait for op_done, and check latency, HI/LO and res
  task automatic do_op(input int op, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] e_hi, e_lo, e_res, got_res;
    logic [63:0] p;
    longint sa, sb, q, r;
    int e_lat, lat;
    bit seen;
    e_hi = m_hi; e_lo = m_lo; e_res = '0; e_lat = 0;
    case (op)
      0, 1: begin
        e_lat = 33;
        if (b == 0) begin
          e_hi = a;
          e_lo = (op == 0 && a[31]) ? 32'h1 : 32'hFFFF_FFFF;
        end else begin
          if (op == 0) begin
            sa = longint'($signed(a)); sb = longint'($signed(b));
          end else begin
            sa = longint'({32'b0, a}); sb = longint'({32'b0, b});
          end
          q = sa / sb; r = sa % sb;
          e_lo = q[31:0]; e_hi = r[31:0];
        end
      end
      2, 3: begin
        e_lat = MUL_LAT;
        if (op == 2) begin
          sa = longint'($signed(a)); sb = longint'($signed(b));
        end else begin
          sa = longint'({32'b0, a}); sb = longint'({32'b0, b});
        end
        p = 64'(sa * sb);
        e_hi = p[63:32]; e_lo = p[31:0];
      end
      4: e_hi = a;
      5: e_lo = a;
      6: e_res = m_hi;
      default: e_res = m_lo;
    endcase

    hi_lo_op = 8'(1 << op);
    src1 = a; src2 = b; op_valid = 1'b1;
    #1;
    seen = 0; lat = 0; got_res = '0;
    for (int c = 0; c <= 40; c++) begin
      if (op_done) begin
        seen = 1; lat = c; got_res = res;
        break;
      end
      @(posedge clk);
      #1;
      src1 = $urandom; src2 = $urandom;
      #1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    next_cycle();
    op_valid = 1'b0; hi_lo_op = '0;
    #1;
    check({tag, "_latency"}, 32'(lat), 32'(e_lat));
    check({tag, "_hi"}, hi, e_hi);
    check({tag, "_lo"}, lo, e_lo);
    if (op >= 6) check({tag, "_res"}, got_res, e_res);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    m_hi = e_hi; m_lo = e_lo;
  endtask

  initial begin
    int op;
    logic [31:0] a, b;

    reset = 1'b1; op_valid = 1'b0; flush = 1'b0; hi_lo_op = '0; src1 = '0; src2 = '0;
    #2;
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(op_done), 32'd0);
    check("rst_res", res, 32'h0);
    next_cycle();
    next_cycle();
    reset = 1'b0;
    next_cycle();

    // mthi then mfhi back-to-back
    hi_lo_op = 8'h10; src1 = 32'h0000_DEAD; op_valid = 1'b1;
    #1;
    check("mthi_done", 32'(op_done), 32'd1);
    next_cycle();
    hi_lo_op = 8'h40;
    #1;
    check("mfhi_done", 32'(op_done), 32'd1);
    check("mfhi_res", res, 32'h0000_DEAD);
    next_cycle();
    op_valid = 1'b0; hi_lo_op = '0;
    m_hi = 32'h0000_DEAD;
    // mtlo with flush is ignored
    hi_lo_op = 8'h20; src1 = 32'h1; op_valid = 1'b1; flush = 1'b1;
    #1;
    check("mtlo_flush_done", 32'(op_done), 32'd0);
    next_cycle();
    op_valid = 1'b0; hi_lo_op = '0; flush = 1'b0;
    #1;
    check("mtlo_flush_lo", lo, m_lo);

    // Multiply corners
    do_op(2, 32'hFFFF_FFFF, 32'h2, "mult");
    check("mult_hi_const", hi, 32'hFFFF_FFFF);
    check("mult_lo_const", lo, 32'hFFFF_FFFE);
    do_op(3, 32'hFFFF_FFFF, 32'h2, "multu");
    check("multu_hi_const", hi, 32'h0000_0001);
    check("multu_lo_const", lo, 32'hFFFF_FFFE);

    // Divide corners
    do_op(0, 32'hFFFF_FFF9, 32'h2, "div_m7_2");
    check("div_m7_lo_const", lo, 32'hFFFF_FFFD);
    check("div_m7_hi_const", hi, 32'hFFFF_FFFF);
    do_op(1, 32'h7, 32'h2, "divu_7_2");
    check("divu_7_lo_const", lo, 32'h3);
    check("divu_7_hi_const", hi, 32'h1);
    do_op(0, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    check("div_ovf_lo_const", lo, 32'h8000_0000);
    check("div_ovf_hi_const", hi, 32'h0);
    do_op(1, 32'h5, 32'h0, "divu_by0");
    check("divu_by0_lo_const", lo, 32'hFFFF_FFFF);
    check("divu_by0_hi_const", hi, 32'h5);
    do_op(0, 32'hFFFF_FFFB, 32'h0, "div_by0");
    check("div_by0_lo_const", lo, 32'h0000_0001);
    check("div_by0_hi_const", hi, 32'hFFFF_FFFB);

    // Flush mid-divide, then mthi accepted in the first IDLE cycle
    do_op(4, 32'h1234_5678, 32'h0, "set_hi");
    do_op(5, 32'h1234_5678, 32'h0, "set_lo");
    hi_lo_op = 8'h01; src1 = 32'hFFFF_FFF9; src2 = 32'h2; op_valid = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    check("flush_done", 32'(op_done), 32'd0);
    check("flush_busy_before", 32'(busy), 32'd1);
    next_cycle();
    flush = 1'b0; hi_lo_op = 8'h10; src1 = 32'hA;
    #1;
    check("flush_busy_after", 32'(busy), 32'd0);
    check("flush_hi_kept", hi, 32'h1234_5678);
    check("flush_lo_kept", lo, 32'h1234_5678);
    check("post_flush_mthi_done", 32'(op_done), 32'd1);
    next_cycle();
    op_valid = 1'b0; hi_lo_op = '0;
    #1;
    check("post_flush_hi", hi, 32'hA);
    m_hi = 32'hA;

    // Asynchronous reset mid-divide at cnt=12
    hi_lo_op = 8'h02; src1 = 32'h1000; src2 = 32'h3; op_valid = 1'b1;
    repeat (13) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_hi", hi, 32'h0);
    check("midrst_lo", lo, 32'h0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(op_done), 32'd0);
    op_valid = 1'b0; hi_lo_op = '0;
    next_cycle();
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    next_cycle();

    // Random ops against the model, operands scrambled while busy
    for (int k = 0; k < 40; k++) begin
      op = $urandom_range(0, 7);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = 32'($urandom_range(1, 15));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: ;
      endcase
      do_op(op, a, b, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
